// File: rtl/pipe_barrel_shifter.sv
// pipe_barrel_shifter
//   Pipelined barrel shifter with one stage per shift-amount bit. Stage k
//   shifts by 2^k when its carried shamt bit k is set. The whole pipeline
//   advances together and stalls globally on downstream backpressure.
//
//   Build option: define PIPE_BARREL_SHIFTER_OVF_EN to implement left-shift
//   overflow detection. Without it, ovf is tied to 0 and no overflow logic
//   is built.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   operand accepted this cycle when in_valid is also high
//   din        operand, DW bits
//   shamt      shift amount, SW bits (0..DW-1)
//   mode       00 lsl, 01 lsr, 10 asr, 11 rotate left
//   out_valid  result valid
//   out_ready  downstream accepts result
//   dout       shifted result
//   ovf        left-shift overflow, qualified by out_valid
module pipe_barrel_shifter #(
  parameter int DW = 32,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  input  logic [SW-1:0] shamt,
  input  logic [1:0]    mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout,
  output logic          ovf
);

  if (SW != $clog2(DW)) begin : g_bad_sw
    $error("pipe_barrel_shifter: SW must equal log2(DW)");
  end
  if (DW < 8 || DW > 64 || (DW & (DW - 1)) != 0) begin : g_bad_dw
    $error("pipe_barrel_shifter: DW must be a power of two from 8 to 64");
  end

  // Index 0 is the pipeline input; index k+1 is the register of stage k.
  logic [SW:0]                v_s;
  logic [SW:0][DW-1:0]        d_s;
  logic [SW-1:0][SW-1:0]      sh_s;
  logic [SW-1:0][1:0]         m_s;
  logic                       advance;

  assign in_ready = !out_valid || out_ready;
  assign advance  = in_ready;

  assign v_s[0]  = in_valid;
  assign d_s[0]  = din;
  assign sh_s[0] = shamt;
  assign m_s[0]  = mode;

  // Later stages only look at their own shamt bit; the rest ride along.
  logic sh_unused;
  assign sh_unused = ^sh_s;

`ifdef PIPE_BARREL_SHIFTER_OVF_EN
  logic [SW:0] o_s;
  assign o_s[0] = 1'b0;
`endif

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int S = 1 << k;

    logic [DW-1:0] nxt;
    logic          v_q;
    logic [DW-1:0] d_q;

    always_comb begin
      nxt = d_s[k];
      if (sh_s[k][k]) begin
        case (m_s[k])
          2'b00:   nxt = {d_s[k][DW-1-S:0], {S{1'b0}}};
          2'b01:   nxt = {{S{1'b0}}, d_s[k][DW-1:S]};
          // The MSB stays the original sign through every earlier asr stage.
          2'b10:   nxt = {{S{d_s[k][DW-1]}}, d_s[k][DW-1:S]};
          default: nxt = {d_s[k][DW-1-S:0], d_s[k][DW-1:DW-S]};
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (advance) begin
        v_q <= v_s[k];
        d_q <= nxt;
      end
    end

    assign v_s[k+1] = v_q;
    assign d_s[k+1] = d_q;

    if (k < SW - 1) begin : g_ctl
      logic [SW-1:0] sh_q;
      logic [1:0]    m_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_q <= '0;
          m_q  <= 2'b00;
        end else if (advance) begin
          sh_q <= sh_s[k];
          m_q  <= m_s[k];
        end
      end

      assign sh_s[k+1] = sh_q;
      assign m_s[k+1]  = m_q;
    end

`ifdef PIPE_BARREL_SHIFTER_OVF_EN
    logic nxt_o;
    logic o_q;

    // Sticky: any 1 pushed past the MSB in any left-shift stage.
    always_comb begin
      nxt_o = o_s[k];
      if (sh_s[k][k] && (m_s[k] == 2'b00) && (|d_s[k][DW-1:DW-S]))
        nxt_o = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        o_q <= 1'b0;
      else if (advance)
        o_q <= nxt_o;
    end

    assign o_s[k+1] = o_q;
`endif
  end

  assign out_valid = v_s[SW];
  assign dout      = d_s[SW];

`ifdef PIPE_BARREL_SHIFTER_OVF_EN
  assign ovf = o_s[SW] & out_valid;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Testbench for pipe_barrel_shifter (DW=32): directed vectors, a random
// stream with random backpressure checked against a behavioural model,
// and a mid-flight reset.
module tb_pipe_barrel_shifter;
  localparam int DW = 32;
  localparam int SW = 5;
`ifdef PIPE_BARREL_SHIFTER_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] din;
  logic [SW-1:0] shamt;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic          ovf;

  pipe_barrel_shifter #(.DW(DW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .shamt(shamt), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, dout} computed from the shift rules with plain arithmetic.
  function automatic logic [32:0] model(input logic [31:0] d, input int sh, input logic [1:0] m);
    logic [63:0]        w;
    logic [63:0]        rot;
    logic signed [31:0] s;
    logic [31:0]        r;
    logic               o;
    w = {32'b0, d};
    s = d;
    o = 1'b0;
    case (m)
      2'b00: begin
        r = d << sh;
        o = OVF_EN && (sh != 0) && ((w >> (32 - sh)) != 64'd0);
      end
      2'b01: r = d >> sh;
      2'b10: r = s >>> sh;
      default: begin
        rot = w << sh;
        r   = rot[31:0] | rot[63:32];
      end
    endcase
    return {o, r};
  endfunction

  task automatic run_one(input string tag, input logic [31:0] d, input int sh,
                         input logic [1:0] m, input logic [31:0] exp_d, input logic exp_o);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    din       = d;
    shamt     = sh[SW-1:0];
    mode      = m;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_latency"}, lat, SW);
    chk({tag, "_dout"}, dout, exp_d);
    chk({tag, "_ovf"}, ovf, exp_o);
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] e;
    logic        stalled;
    logic        acc;
    logic [31:0] held_d;
    logic        held_o;
    int          sent, got, cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din       = '0;
    shamt     = '0;
    mode      = 2'b00;
    out_ready = 1'b0;

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    run_one("lsl31", 32'h0000_0001, 31, 2'b00, 32'h8000_0000, 1'b0);
    run_one("asr4", 32'h8000_0000, 4, 2'b10, 32'hF800_0000, 1'b0);
    run_one("lsr4", 32'h8000_0000, 4, 2'b01, 32'h0800_0000, 1'b0);
    run_one("rol8", 32'hF000_000F, 8, 2'b11, 32'h0000_0FF0, 1'b0);
    run_one("lsl8", 32'hF000_000F, 8, 2'b00, 32'h0000_0F00, OVF_EN);
    run_one("lsl0", 32'hDEAD_BEEF, 0, 2'b00, 32'hDEAD_BEEF, 1'b0);
    run_one("asr0", 32'h8765_4321, 0, 2'b10, 32'h8765_4321, 1'b0);
    run_one("rol31", 32'h8000_0001, 31, 2'b11, 32'hC000_0000, 1'b0);

    // Random stream with random backpressure.
    sent    = 0;
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    acc     = 1'b0;
    held_d  = '0;
    held_o  = 1'b0;
    in_valid = 1'b0;
    while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_dout", dout, held_d);
        chk("hold_ovf", ovf, held_o);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid || acc) begin
        if (sent < 100) begin
          in_valid = 1'b1;
          din      = $urandom;
          shamt    = SW'($urandom_range(0, 31));
          mode     = 2'($urandom_range(0, 3));
        end else begin
          in_valid = 1'b0;
        end
      end
      acc = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_extra_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("stream_dout", dout, e[31:0]);
          chk("stream_ovf", ovf, e[32]);
          got++;
        end
      end
      stalled = out_valid && !out_ready;
      held_d  = dout;
      held_o  = ovf;
      if (in_valid && in_ready) begin
        q.push_back(model(din, int'(shamt), mode));
        sent++;
        acc = 1'b1;
      end
    end
    chk("stream_count", got, 100);
    chk("stream_queue_empty", q.size(), 0);

    // Fill three stages, then reset.
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (SW + 1) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      din      = $urandom | 32'h1;
      shamt    = SW'(i + 1);
      mode     = 2'b00;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_dout", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_in_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_no_result", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
